// File: rtl/window7_gen.sv
// 7-sample sliding window with replicate-border padding, one window per input sample.
// Latency: window for centre x-3 is valid one cycle after p_x is accepted; 3 flush cycles close each line.
module window7_gen #(
  parameter int DATA_WIDTH = 14,
  parameter int LINE_LEN   = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sync_clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_value,
  output logic                    out_window_valid,
  output logic [7*DATA_WIDTH-1:0] out_window_value,
  output logic                    out_line_end
);

  localparam int CW = $clog2(LINE_LEN);
  localparam int SW = 7 * DATA_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(LINE_LEN - 1);

  typedef enum logic [1:0] {ST_START, ST_RUN, ST_FLUSH} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      fcnt_q, fcnt_d;
  logic [SW-1:0]   sreg_q, sreg_d;
  logic            vld_q, vld_d;
  logic            le_q, le_d;
  logic            accept;

  assign in_ready = (state_q != ST_FLUSH);
  assign accept   = in_valid && in_ready && !sync_clr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    sreg_d  = sreg_q;
    vld_d   = 1'b0;
    le_d    = 1'b0;
    if (sync_clr) begin
      state_d = ST_START;
      cnt_d   = '0;
      fcnt_d  = '0;
    end else begin
      case (state_q)
        ST_START: begin
          if (accept) begin
            sreg_d  = {7{in_value}};
            cnt_d   = CW'(1);
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept) begin
            sreg_d = {in_value, sreg_q[SW-1:DATA_WIDTH]};
            cnt_d  = cnt_q + CW'(1);
            vld_d  = (cnt_q >= CW'(3));
            if (cnt_q == LAST) begin
              state_d = ST_FLUSH;
              fcnt_d  = '0;
            end
          end
        end
        ST_FLUSH: begin
          // Replicate the last sample to pad the right border.
          sreg_d = {sreg_q[SW-1:SW-DATA_WIDTH], sreg_q[SW-1:DATA_WIDTH]};
          vld_d  = 1'b1;
          fcnt_d = fcnt_q + 2'd1;
          if (fcnt_q == 2'd2) begin
            le_d    = 1'b1;
            state_d = ST_START;
            cnt_d   = '0;
            fcnt_d  = '0;
          end
        end
        default: begin
          state_d = ST_START;
          cnt_d   = '0;
          fcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_START;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      sreg_q  <= '0;
      vld_q   <= 1'b0;
      le_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      sreg_q  <= sreg_d;
      vld_q   <= vld_d;
      le_q    <= le_d;
    end
  end

  assign out_window_valid = vld_q;
  assign out_window_value = sreg_q;
  assign out_line_end     = le_q;

endmodule
